// File: rtl/fft_frame_scheduler.sv
// Overlapping FFT frame sequencer: reads one 16-bit sample per 4-byte word and streams frames to the FFT core.
// Optional: define FFT_PAD_TAIL_EN to emit a final zero-padded partial frame per segment.
module fft_frame_scheduler #(
  parameter int unsigned FRAME_LEN = 256,
  parameter int unsigned HOP       = 128,
  parameter int unsigned RD_LAT    = 1
) (
  input  logic        iclk,
  input  logic        irst,
  input  logic        i_seg_valid,
  input  logic [31:0] i_frame_start,
  input  logic [31:0] i_frame_end,
  output logic        o_rd_en,
  output logic [31:0] o_rd_addr,
  input  logic [15:0] i_rd_data,
  output logic [15:0] o_fft_data,
  output logic        o_fft_valid,
  output logic        o_fft_last,
  input  logic        i_fft_ready,
  output logic [15:0] o_frame_idx,
  output logic        o_seg_done,
  output logic        o_busy,
  output logic        o_overflow
);

  localparam int unsigned KW   = $clog2(FRAME_LEN) + 1;
  localparam logic [33:0] SPAN = 34'((FRAME_LEN - 1) * 4);
  localparam logic [33:0] HOPB = 34'(HOP * 4);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STREAM, S_NEXT, S_DONE} state_t;
  state_t r_state, w_state_nxt;

  logic          r_pend_full;
  logic [31:0]   r_pend_start, r_pend_end, r_end;
  logic [33:0]   r_cur, r_rd_addr;
  logic [15:0]   r_idx;
  logic          r_tail, r_overflow;
  logic [KW-1:0] r_rd_k, r_out_k;
  logic [RD_LAT-1:0] r_pipe_v, r_pipe_z;
  logic [15:0]   r_skid [2];
  logic          r_wp, r_rp;
  logic [1:0]    r_cnt;

  logic        w_pop, w_fits, w_tail_go, w_head_v, w_hs, w_last_hs;
  logic        w_issue, w_rd_real, w_arrive, w_arrive_z;
  logic [33:0] w_cand, w_end34;
  logic [1:0]  w_infl, w_skid_after;

  always_comb begin
    w_pop     = (r_state == S_IDLE) && r_pend_full;
    w_cand    = (r_state == S_NEXT) ? (r_cur + HOPB) : r_cur;
    w_end34   = {2'b00, r_end};
    w_fits    = (w_cand + SPAN) <= w_end34;
`ifdef FFT_PAD_TAIL_EN
    w_tail_go = !((r_state == S_NEXT) && r_tail) && (w_cand <= w_end34);
`else
    w_tail_go = 1'b0;
`endif
    w_head_v  = (r_cnt != 2'd0);
    w_hs      = w_head_v && i_fft_ready;
    w_last_hs = w_hs && (r_out_k == KW'(FRAME_LEN - 1));
    w_infl    = '0;
    for (int unsigned i = 0; i < RD_LAT; i++) w_infl = w_infl + {1'b0, r_pipe_v[i]};
    // Occupancy is taken after this cycle's pop so a ready sink sees one sample per cycle.
    w_skid_after = r_cnt - {1'b0, w_hs};
    w_issue   = (r_state == S_STREAM) && (r_rd_k < KW'(FRAME_LEN)) &&
                (({1'b0, w_infl} + {1'b0, w_skid_after}) < 3'd2);
    w_rd_real = !r_tail || (r_rd_addr <= w_end34);
    w_arrive   = r_pipe_v[RD_LAT-1];
    w_arrive_z = r_pipe_z[RD_LAT-1];
  end

  always_ff @(posedge iclk or posedge irst) begin
    if (irst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (r_pend_full) w_state_nxt = S_SETUP;
      S_SETUP,
      S_NEXT:   w_state_nxt = (w_fits || w_tail_go) ? S_STREAM : S_DONE;
      S_STREAM: if (w_last_hs) w_state_nxt = S_NEXT;
      S_DONE:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    o_busy     = (r_state != S_IDLE);
    o_seg_done = (r_state == S_DONE);
    o_rd_en    = w_issue && w_rd_real;
  end

  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      r_pend_full  <= 1'b0;
      r_pend_start <= '0;
      r_pend_end   <= '0;
      r_overflow   <= 1'b0;
      r_end        <= '0;
      r_cur        <= '0;
      r_rd_addr    <= '0;
      r_idx        <= '0;
      r_tail       <= 1'b0;
      r_rd_k       <= '0;
      r_out_k      <= '0;
      r_pipe_v     <= '0;
      r_pipe_z     <= '0;
      r_skid[0]    <= '0;
      r_skid[1]    <= '0;
      r_wp         <= 1'b0;
      r_rp         <= 1'b0;
      r_cnt        <= '0;
    end else begin
      if (i_seg_valid && (!r_pend_full || w_pop)) begin
        r_pend_full  <= 1'b1;
        r_pend_start <= i_frame_start;
        r_pend_end   <= i_frame_end;
      end else if (w_pop) begin
        r_pend_full <= 1'b0;
      end
      if (i_seg_valid && r_pend_full && !w_pop) r_overflow <= 1'b1;

      if (w_pop) begin
        r_cur  <= {2'b00, r_pend_start};
        r_end  <= r_pend_end;
        r_idx  <= '0;
        r_tail <= 1'b0;
      end
      if ((r_state == S_SETUP) || (r_state == S_NEXT)) begin
        if (r_state == S_NEXT) r_idx <= r_idx + 16'd1;
        r_cur     <= w_cand;
        r_rd_addr <= w_cand;
        r_rd_k    <= '0;
        r_out_k   <= '0;
        r_tail    <= !w_fits && w_tail_go;
      end
      if (w_issue) begin
        r_rd_k    <= r_rd_k + KW'(1);
        r_rd_addr <= r_rd_addr + 34'd4;
      end
      if (w_hs) r_out_k <= r_out_k + KW'(1);

      // Padding positions travel the read pipeline as zero-tagged slots to keep beat order.
      r_pipe_v[0] <= w_issue;
      r_pipe_z[0] <= w_issue && !w_rd_real;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        r_pipe_v[i] <= r_pipe_v[i-1];
        r_pipe_z[i] <= r_pipe_z[i-1];
      end

      if (w_arrive) begin
        r_skid[r_wp] <= w_arrive_z ? '0 : i_rd_data;
        r_wp         <= ~r_wp;
      end
      if (w_hs) r_rp <= ~r_rp;
      r_cnt <= r_cnt + {1'b0, w_arrive} - {1'b0, w_hs};
    end
  end

  assign o_rd_addr   = r_rd_addr[31:0];
  assign o_fft_data  = r_skid[r_rp];
  assign o_fft_valid = w_head_v;
  assign o_fft_last  = w_head_v && (r_out_k == KW'(FRAME_LEN - 1));
  assign o_frame_idx = r_idx;
  assign o_overflow  = r_overflow;

endmodule

// File: tb/tb_fft_frame_scheduler.sv
// Self-checking bench for fft_frame_scheduler: random ready/data against a frame-list reference model.
module tb_fft_frame_scheduler;
  localparam int FL = 256;
  localparam int HP = 128;
  localparam int RL = 1;

  logic        iclk = 1'b0, irst = 1'b1;
  logic        i_seg_valid = 1'b0;
  logic [31:0] i_frame_start = '0, i_frame_end = '0;
  logic        o_rd_en;
  logic [31:0] o_rd_addr;
  logic [15:0] i_rd_data = '0;
  logic [15:0] o_fft_data;
  logic        o_fft_valid, o_fft_last;
  logic        i_fft_ready = 1'b0;
  logic [15:0] o_frame_idx;
  logic        o_seg_done, o_busy, o_overflow;

  fft_frame_scheduler #(.FRAME_LEN(FL), .HOP(HP), .RD_LAT(RL)) dut (
    .iclk(iclk), .irst(irst), .i_seg_valid(i_seg_valid),
    .i_frame_start(i_frame_start), .i_frame_end(i_frame_end),
    .o_rd_en(o_rd_en), .o_rd_addr(o_rd_addr), .i_rd_data(i_rd_data),
    .o_fft_data(o_fft_data), .o_fft_valid(o_fft_valid), .o_fft_last(o_fft_last),
    .i_fft_ready(i_fft_ready), .o_frame_idx(o_frame_idx), .o_seg_done(o_seg_done),
    .o_busy(o_busy), .o_overflow(o_overflow)
  );

  always #5 iclk = ~iclk;

  typedef struct {logic [15:0] d; logic l; logic [15:0] idx;} beat_t;

  int n_assert = 0, n_fail = 0;
  logic [15:0] salt;
  logic [31:0] exp_rd[$], got_rd[$];
  beat_t       exp_bt[$], got_bt[$];
  logic [31:0] drv_s[3], drv_e[3];
  int first_rd, first_v, last_cyc, done_cyc, done_idx, ndone;

  function automatic logic [15:0] mem(input logic [31:0] a);
    return a[17:2] ^ a[31:16] ^ salt;
  endfunction

  // Sample RAM with one cycle of read latency
  always @(posedge iclk) if (o_rd_en) i_rd_data <= mem(o_rd_addr);

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: frames at start + f*HOP*4 while a whole frame fits inside [start, end].
  task automatic model_seg(input longint s, input longint e);
    longint base;
    int f;
    beat_t b;
    f = 0;
    base = s;
    while (e >= s && base + (FL - 1) * 4 <= e) begin
      for (int k = 0; k < FL; k++) begin
        exp_rd.push_back(32'(base + 4 * k));
        b.d = mem(32'(base + 4 * k)); b.l = (k == FL - 1); b.idx = 16'(f);
        exp_bt.push_back(b);
      end
      f++;
      base = base + HP * 4;
    end
`ifdef FFT_PAD_TAIL_EN
    if (e >= s && base <= e) begin
      for (int k = 0; k < FL; k++) begin
        if (base + 4 * k <= e) begin
          exp_rd.push_back(32'(base + 4 * k));
          b.d = mem(32'(base + 4 * k));
        end else b.d = '0;
        b.l = (k == FL - 1); b.idx = 16'(f);
        exp_bt.push_back(b);
      end
    end
`endif
  endtask

  task automatic clear_q();
    exp_rd.delete(); got_rd.delete(); exp_bt.delete(); got_bt.delete();
  endtask

  task automatic compare_q();
    chk("read_count", 64'(got_rd.size()), 64'(exp_rd.size()));
    for (int i = 0; i < got_rd.size() && i < exp_rd.size(); i++)
      chk($sformatf("rd_addr[%0d]", i), 64'(got_rd[i]), 64'(exp_rd[i]));
    chk("beat_count", 64'(got_bt.size()), 64'(exp_bt.size()));
    for (int i = 0; i < got_bt.size() && i < exp_bt.size(); i++) begin
      chk($sformatf("data[%0d]", i), 64'(got_bt[i].d), 64'(exp_bt[i].d));
      chk($sformatf("last[%0d]", i), 64'(got_bt[i].l), 64'(exp_bt[i].l));
      chk($sformatf("idx[%0d]", i), 64'(got_bt[i].idx), 64'(exp_bt[i].idx));
    end
  endtask

  // Drives n segment pulses gap cycles apart and records reads/beats until exp_done completions.
  task automatic run(input int n, input int gap, input int ready_pct, input int exp_done);
    int cyc;
    logic held;
    beat_t hb, b;
    cyc = 0; held = 1'b0; ndone = 0;
    first_rd = -1; first_v = -1; last_cyc = -1; done_cyc = -1; done_idx = -1;
    while (ndone < exp_done && cyc < 20000) begin
      @(negedge iclk);
      i_seg_valid = 1'b0;
      for (int i = 0; i < n; i++)
        if (cyc == i * gap) begin
          i_seg_valid = 1'b1; i_frame_start = drv_s[i]; i_frame_end = drv_e[i];
        end
      i_fft_ready = ($urandom_range(0, 99) < ready_pct);
      #1;
      if (o_rd_en) begin
        got_rd.push_back(o_rd_addr);
        if (first_rd < 0) first_rd = cyc;
      end
      if (o_fft_valid) begin
        if (first_v < 0) first_v = cyc;
        b.d = o_fft_data; b.l = o_fft_last; b.idx = o_frame_idx;
        if (held) begin
          chk("stall_data", 64'(b.d), 64'(hb.d));
          chk("stall_last", 64'(b.l), 64'(hb.l));
        end
        if (i_fft_ready) begin
          got_bt.push_back(b);
          if (b.l) last_cyc = cyc;
          held = 1'b0;
        end else begin
          hb = b; held = 1'b1;
        end
      end else held = 1'b0;
      if (o_seg_done) begin
        ndone++; done_cyc = cyc; done_idx = int'(o_frame_idx);
      end
      cyc++;
    end
    chk("run_timeout", 64'(ndone), 64'(exp_done));
    i_seg_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge iclk); #1;
      chk("post_done_pulse", 64'(o_seg_done), 64'd0);
      chk("post_busy", 64'(o_busy), 64'd0);
    end
  endtask

  initial begin
    int beats, t;
    salt = 16'($urandom);
    #1;
    chk("rst_rd_en", 64'(o_rd_en), 64'd0);
    chk("rst_valid", 64'(o_fft_valid), 64'd0);
    chk("rst_busy_ovf_done", 64'({o_busy, o_overflow, o_seg_done, o_fft_last}), 64'd0);
    chk("rst_idx_addr", 64'({o_frame_idx, o_rd_addr}), 64'd0);
    @(negedge iclk); irst = 1'b0;
    @(negedge iclk);

    // Single frame, ready held high: latency and completion timing
    clear_q(); drv_s[0] = 32'h000; drv_e[0] = 32'h3FC; model_seg(drv_s[0], drv_e[0]);
    run(1, 1, 100, 1); compare_q();
    chk("first_rd_latency", 64'(first_rd), 64'd3);
    chk("first_valid_latency", 64'(first_v - first_rd), 64'(RL + 1));
    chk("done_after_last", 64'((done_cyc - last_cyc) >= 1 && (done_cyc - last_cyc) <= 2), 64'd1);

    // Overlapping frames, ready high then random
    clear_q(); drv_s[0] = 32'h000; drv_e[0] = 32'h7FC; model_seg(drv_s[0], drv_e[0]);
    run(1, 1, 100, 1); compare_q();
    clear_q(); model_seg(drv_s[0], drv_e[0]);
    run(1, 1, 50, 1); compare_q();

    // End before start: no frames at all
    clear_q(); drv_s[0] = 32'h100; drv_e[0] = 32'h0FC; model_seg(drv_s[0], drv_e[0]);
    run(1, 1, 100, 1); compare_q();
    chk("neg_seg_idx", 64'(done_idx), 64'd0);

    // One sample short of a full frame
    clear_q(); drv_s[0] = 32'h000; drv_e[0] = 32'h3F8; model_seg(drv_s[0], drv_e[0]);
    run(1, 1, 70, 1); compare_q();
`ifndef FFT_PAD_TAIL_EN
    chk("short_seg_idx", 64'(done_idx), 64'd0);
`endif

    // Three back-to-back pulses: third is dropped
    chk("ovf_before", 64'(o_overflow), 64'd0);
    clear_q();
    drv_s[0] = 32'h4000; drv_e[0] = 32'h43FC;
    drv_s[1] = 32'h8000; drv_e[1] = 32'h87FC;
    drv_s[2] = 32'hC000; drv_e[2] = 32'hC3FC;
    model_seg(drv_s[0], drv_e[0]); model_seg(drv_s[1], drv_e[1]);
    run(3, 1, 100, 2); compare_q();
    chk("ovf_after", 64'(o_overflow), 64'd1);

    // Reset in the middle of a frame
    clear_q(); beats = 0; t = 0;
    @(negedge iclk);
    i_seg_valid = 1'b1; i_frame_start = 32'h1000; i_frame_end = 32'h13FC; i_fft_ready = 1'b1;
    @(negedge iclk); i_seg_valid = 1'b0;
    while (beats < 100 && t < 2000) begin
      #1; if (o_fft_valid && i_fft_ready) beats++;
      @(negedge iclk); t++;
    end
    chk("mid_reset_reach", 64'(beats), 64'd100);
    #2 irst = 1'b1;
    #1;
    chk("arst_valid_last", 64'({o_fft_valid, o_fft_last}), 64'd0);
    chk("arst_busy_rd", 64'({o_busy, o_rd_en, o_seg_done}), 64'd0);
    chk("arst_ovf", 64'(o_overflow), 64'd0);
    chk("arst_data", 64'({o_fft_data, o_frame_idx, o_rd_addr}), 64'd0);
    @(negedge iclk); @(negedge iclk); irst = 1'b0;
    @(negedge iclk); #1;
    chk("post_rst_idle", 64'({o_busy, o_fft_valid}), 64'd0);

    clear_q(); drv_s[0] = 32'h2000; drv_e[0] = 32'h25FC; model_seg(drv_s[0], drv_e[0]);
    run(1, 1, 60, 1); compare_q();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
